// File: rtl/varint_decoder.sv
// varint_decoder
//   Streaming unsigned LEB128 (protobuf varint) decoder. It pops encoded bytes
//   from a byte FIFO and accumulates the 7-bit groups LSB-first. A byte with
//   bit 7 clear ends the value, and the 32-bit result is then pushed into a
//   word FIFO.
//
//   Optional feature macro: VARINT_DEC_OVERFLOW_CHECK_EN
//     When defined, a value that does not fit in 32 bits sets the sticky
//     varint_err flag. Its remaining bytes are drained and it is not pushed.
//     When undefined, excess bits are truncated, varint_err is tied to 0, and
//     the DRAIN state does not exist.
//
// Ports:
//   clk                    clock, all state on rising edge
//   reset                  synchronous, active-high
//   varint_in_fifo_empty   byte FIFO empty
//   varint_in_fifo_pop     pop one byte; data valid on varint_data_in next cycle
//   varint_in_index_pop    companion index FIFO pop, mirrors varint_in_fifo_pop
//   varint_data_in         encoded byte, bit 7 = continuation
//   varint_out_fifo_full   word FIFO full
//   varint_out_fifo_clr    clear word FIFO
//   varint_out_index_clr   clear companion index FIFO
//   varint_out_fifo_push   push varint_data_out
//   varint_out_index_push  mirrors varint_out_fifo_push
//   varint_data_out        decoded value (the accumulator register)
//   varint_err             sticky overflow flag, cleared only by reset
module varint_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        varint_in_fifo_empty,
    output logic        varint_in_fifo_pop,
    output logic        varint_in_index_pop,
    input  logic [7:0]  varint_data_in,
    input  logic        varint_out_fifo_full,
    output logic        varint_out_fifo_clr,
    output logic        varint_out_index_clr,
    output logic        varint_out_fifo_push,
    output logic        varint_out_index_push,
    output logic [31:0] varint_data_out,
    output logic        varint_err
);

`ifdef VARINT_DEC_OVERFLOW_CHECK_EN
    typedef enum logic [4:0] {
        StInit  = 5'b00001,
        StFetch = 5'b00010,
        StLoad  = 5'b00100,
        StEmit  = 5'b01000,
        StDrain = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        StInit  = 4'b0001,
        StFetch = 4'b0010,
        StLoad  = 4'b0100,
        StEmit  = 4'b1000
    } state_t;
`endif

    state_t      state;
    logic [31:0] acc;
    logic [2:0]  idx;
    logic [31:0] group_shifted;
    logic        fetching;

`ifdef VARINT_DEC_OVERFLOW_CHECK_EN
    logic draining;  // the byte in LOAD belongs to an overflowed value
    logic err_q;
    logic overflow;

    // The fifth group only has room for bits [3:0]. A continuation bit there
    // also means the value has more than 32 bits.
    always_comb overflow = (idx == 3'd4) && (varint_data_in[7] || (|varint_data_in[6:4]));
    always_comb fetching = (state == StFetch) || (state == StDrain);
    assign varint_err = err_q;
`else
    always_comb fetching = (state == StFetch);
    assign varint_err = 1'b0;
`endif

    // Bits shifted past bit 31 fall off the 32-bit result.
    always_comb group_shifted = 32'(varint_data_in[6:0]) << (5'(idx) * 5'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StInit;
            acc   <= '0;
            idx   <= '0;
`ifdef VARINT_DEC_OVERFLOW_CHECK_EN
            draining <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                StInit: begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= StFetch;
                end
                StFetch: begin
                    if (!varint_in_fifo_empty) state <= StLoad;
                end
                StLoad: begin
`ifdef VARINT_DEC_OVERFLOW_CHECK_EN
                    if (draining) begin
                        if (!varint_data_in[7]) begin
                            draining <= 1'b0;
                            state    <= StFetch;
                        end else begin
                            state <= StDrain;
                        end
                    end else if (overflow) begin
                        err_q    <= 1'b1;
                        acc      <= '0;
                        idx      <= '0;
                        draining <= varint_data_in[7];
                        state    <= varint_data_in[7] ? StDrain : StFetch;
                    end else begin
`else
                    begin
`endif
                        // Once five groups are in, further groups are dropped.
                        if (idx < 3'd5) begin
                            acc <= acc | group_shifted;
                            idx <= idx + 3'd1;
                        end
                        state <= varint_data_in[7] ? StFetch : StEmit;
                    end
                end
                StEmit: begin
                    if (!varint_out_fifo_full) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= StFetch;
                    end
                end
`ifdef VARINT_DEC_OVERFLOW_CHECK_EN
                StDrain: begin
                    if (!varint_in_fifo_empty) state <= StLoad;
                end
`endif
                default: state <= StInit;
            endcase
        end
    end

    always_comb begin
        varint_in_fifo_pop    = fetching && !varint_in_fifo_empty;
        varint_in_index_pop   = varint_in_fifo_pop;
        varint_out_fifo_clr   = (state == StInit);
        varint_out_index_clr  = varint_out_fifo_clr;
        varint_out_fifo_push  = (state == StEmit) && !varint_out_fifo_full;
        varint_out_index_push = varint_out_fifo_push;
        varint_data_out       = acc;
    end

endmodule
